fpu_normalize_pack: RTL

- Back-end stage of the floating point unit.
- Consumes the raw sign / biased exponent / extended mantissa produced by the sum/sub/mul arithmetic stages.
- Normalizes iteratively (one shift per clock), rounds to nearest-even and packs an IEEE-754 word of width `bitness`.
- Valid/ready handshake on both sides so the arithmetic stage can stall on it.

---
 rtl/fpu_normalize_pack.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fpu_normalize_pack.sv
// FPU back-end: iterative normalize (one shift per clock), round-to-nearest-even, IEEE pack.
// Optional status flags (overflow/underflow/inexact) enabled by defining FPU_NORM_FLAGS_EN.
module fpu_normalize_pack #(
  parameter int bitness = 32,
  localparam int EXP_W  = (bitness == 16)  ? 5  :
                          (bitness == 32)  ? 8  :
                          (bitness == 64)  ? 11 :
                          (bitness == 128) ? 15 : 19,
  localparam int MANT_W = (bitness == 16)  ? 11  :
                          (bitness == 32)  ? 24  :
                          (bitness == 64)  ? 53  :
                          (bitness == 128) ? 113 : 237,
  localparam int IN_W   = MANT_W + 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W+1:0] in_exp,
  input  logic [IN_W-1:0]         in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [bitness-1:0]      result
`ifdef FPU_NORM_FLAGS_EN
  ,
  output logic                    flag_overflow,
  output logic                    flag_underflow,
  output logic                    flag_inexact
`endif
);

  localparam int XW = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_INF = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_MAX = {1'b0, {(XW-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, HOLD} state_t;

  state_t                 state, state_n;
  logic                   sign_q, sign_n;
  logic signed [XW-1:0]   exp_q, exp_n, exp_inc;
  logic [IN_W-1:0]        mant_q, mant_n, mant_shr, mant_shl;
  logic [MANT_W-1:0]      sig;
  logic [MANT_W:0]        sig_inc;
  logic                   hidden, round_up;
  logic [bitness-1:0]     result_n;
  logic                   out_valid_n;

  assign in_ready = (state == IDLE);

  // Exponent saturates at the top of its signed range instead of wrapping.
  assign exp_inc  = (exp_q == EXP_MAX) ? exp_q : exp_q + EXP_ONE;
  assign mant_shr = {1'b0, mant_q[IN_W-1:2], mant_q[1] | mant_q[0]};
  assign mant_shl = {mant_q[IN_W-2:0], 1'b0};
  assign sig      = mant_q[IN_W-2:3];
  assign sig_inc  = {1'b0, sig} + (MANT_W+1)'(1);
  assign hidden   = mant_q[IN_W-2];
  assign round_up = mant_q[2] & (mant_q[1] | mant_q[0] | sig[0]);

  always_comb begin
    state_n     = state;
    sign_n      = sign_q;
    exp_n       = exp_q;
    mant_n      = mant_q;
    result_n    = result;
    out_valid_n = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n  = in_sign;
          exp_n   = in_exp;
          mant_n  = in_mant;
          state_n = NORM;
        end
      end
      NORM: begin
        if (mant_q == '0) begin
          state_n = ROUND;
        end else if (mant_q[IN_W-1] || (exp_q < EXP_ONE)) begin
          mant_n = mant_shr;
          exp_n  = exp_inc;
        end else if (!hidden && (exp_q > EXP_ONE)) begin
          mant_n = mant_shl;
          exp_n  = exp_q - EXP_ONE;
        end else begin
          state_n = ROUND;
        end
      end
      ROUND: begin
        if (round_up && sig_inc[MANT_W]) begin
          mant_n = {1'b0, 1'b1, {(MANT_W-1){1'b0}}, 3'b000};
          exp_n  = exp_inc;
        end else if (round_up) begin
          mant_n = {1'b0, sig_inc[MANT_W-1:0], 3'b000};
        end else begin
          mant_n = {1'b0, sig, 3'b000};
        end
        state_n = PACK;
      end
      PACK: begin
        if (!hidden)
          result_n = {sign_q, {EXP_W{1'b0}}, mant_q[IN_W-3:3]};
        else if (exp_q >= EXP_INF)
          result_n = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
        else
          result_n = {sign_q, exp_q[EXP_W-1:0], mant_q[IN_W-3:3]};
        out_valid_n = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      sign_q    <= sign_n;
      exp_q     <= exp_n;
      mant_q    <= mant_n;
      result    <= result_n;
      out_valid <= out_valid_n;
    end
  end

`ifdef FPU_NORM_FLAGS_EN
  logic inexact_q;

  // Inexact is sampled before rounding clears G/R/S; flags then follow result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inexact_q      <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else begin
      if (state == ROUND)
        inexact_q <= mant_q[2] | mant_q[1] | mant_q[0];
      if (state == PACK) begin
        flag_overflow  <= hidden && (exp_q >= EXP_INF);
        flag_underflow <= !hidden && inexact_q;
        flag_inexact   <= inexact_q;
      end
    end
  end
`endif

endmodule
